// File: rtl/window_reader.sv
// Window reader: gathers ADDR_LENGTH scratchpad reads into one window word.
// Optional one-entry input skid buffer: define WINDOW_READER_SKID_EN.
module window_reader #(
    parameter int ROWS        = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int ADDR_LENGTH = 9,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                                         i_clk,
    input  logic                                         i_nrst,
    input  logic                                         i_reg_clear,
    input  logic                                         i_valid,
    output logic                                         o_ready,
    input  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]       i_addr,
    input  logic [ADDR_WIDTH-1:0]                        i_o_x,
    input  logic [ADDR_WIDTH-1:0]                        i_o_y,
    input  logic [ROWS-1:0]                              i_row_id,
    output logic                                         o_mem_re,
    output logic [ADDR_WIDTH-1:0]                        o_mem_addr,
    input  logic [DATA_WIDTH-1:0]                        i_mem_data,
    output logic                                         o_valid,
    input  logic                                         i_ready,
    output logic [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]       o_data,
    output logic [ADDR_WIDTH-1:0]                        o_o_x,
    output logic [ADDR_WIDTH-1:0]                        o_o_y,
    output logic [ROWS-1:0]                              o_row_id,
    output logic                                         o_overflow
);

    localparam int IW = (ADDR_LENGTH > 1) ? $clog2(ADDR_LENGTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(ADDR_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    state_t                                 state, state_nx;
    logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] addr_q;
    logic [IW-1:0]                          idx, idx_d1;
    logic                                   re_d1;
    logic                                   ld_in, ld_skid, park, ovf_set;

`ifdef WINDOW_READER_SKID_EN
    logic                                   skid_full;
    logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] skid_addr;
    logic [ADDR_WIDTH-1:0]                  skid_x, skid_y;
    logic [ROWS-1:0]                        skid_row;
`endif

    always_comb begin
        state_nx = state;
        ld_in    = 1'b0;
        ld_skid  = 1'b0;
        park     = 1'b0;
        ovf_set  = 1'b0;
        o_mem_re = 1'b0;
        o_valid  = 1'b0;
`ifdef WINDOW_READER_SKID_EN
        o_ready  = !skid_full;
`else
        o_ready  = (state == IDLE);
`endif
        unique case (state)
            IDLE: begin
                if (i_valid) begin
                    ld_in    = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                o_mem_re = 1'b1;
                if (idx == LAST) state_nx = DRAIN;
            end
            DRAIN: state_nx = HOLD;
            HOLD: begin
                o_valid = 1'b1;
                if (i_ready) begin
`ifdef WINDOW_READER_SKID_EN
                    // Chain straight into the next window, skipping IDLE
                    if (skid_full) begin
                        ld_skid  = 1'b1;
                        state_nx = FETCH;
                    end else if (i_valid) begin
                        ld_in    = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        state_nx = IDLE;
                    end
`else
                    state_nx = IDLE;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
`ifdef WINDOW_READER_SKID_EN
        park    = i_valid && !skid_full && !ld_in && (state != IDLE);
        ovf_set = i_valid && skid_full;
`else
        ovf_set = i_valid && (state != IDLE);
`endif
        o_mem_addr = o_mem_re ? addr_q[idx] : '0;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state      <= IDLE;
            addr_q     <= '0;
            idx        <= '0;
            idx_d1     <= '0;
            re_d1      <= 1'b0;
            o_data     <= '0;
            o_o_x      <= '0;
            o_o_y      <= '0;
            o_row_id   <= '0;
            o_overflow <= 1'b0;
`ifdef WINDOW_READER_SKID_EN
            skid_full  <= 1'b0;
            skid_addr  <= '0;
            skid_x     <= '0;
            skid_y     <= '0;
            skid_row   <= '0;
`endif
        end else if (i_reg_clear) begin
            state      <= IDLE;
            addr_q     <= '0;
            idx        <= '0;
            idx_d1     <= '0;
            re_d1      <= 1'b0;
            o_data     <= '0;
            o_o_x      <= '0;
            o_o_y      <= '0;
            o_row_id   <= '0;
            o_overflow <= 1'b0;
`ifdef WINDOW_READER_SKID_EN
            skid_full  <= 1'b0;
            skid_addr  <= '0;
            skid_x     <= '0;
            skid_y     <= '0;
            skid_row   <= '0;
`endif
        end else begin
            state  <= state_nx;
            re_d1  <= o_mem_re;
            idx_d1 <= idx;
            if (ld_in) begin
                addr_q   <= i_addr;
                o_o_x    <= i_o_x;
                o_o_y    <= i_o_y;
                o_row_id <= i_row_id;
                idx      <= '0;
`ifdef WINDOW_READER_SKID_EN
            end else if (ld_skid) begin
                addr_q   <= skid_addr;
                o_o_x    <= skid_x;
                o_o_y    <= skid_y;
                o_row_id <= skid_row;
                idx      <= '0;
`endif
            end else if (o_mem_re && idx != LAST) begin
                idx <= idx + 1'b1;
            end
            // Read data returns one cycle after its request
            if (re_d1) o_data[idx_d1] <= i_mem_data;
            if (ovf_set) o_overflow <= 1'b1;
`ifdef WINDOW_READER_SKID_EN
            if (park) begin
                skid_full <= 1'b1;
                skid_addr <= i_addr;
                skid_x    <= i_o_x;
                skid_y    <= i_o_y;
                skid_row  <= i_row_id;
            end else if (ld_skid) begin
                skid_full <= 1'b0;
            end
`else
            if (ld_skid || park) o_overflow <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_window_reader.sv
// Directed self-checking bench for window_reader.
// Scratchpad model returns mem[a] = a + 16 one cycle after each read.
module tb_window_reader;

    localparam int ROWS = 4;
    localparam int AW   = 6;
    localparam int AL   = 9;
    localparam int DW   = 8;

    typedef logic [0:AL-1][AW-1:0] addr_t;
    typedef logic [0:AL-1][DW-1:0] data_t;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          reg_clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          ready;
    addr_t         addr = '0;
    logic [AW-1:0] ox = '0, oy = '0;
    logic [ROWS-1:0] row = '0;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    data_t         data;
    logic [AW-1:0] x_out, y_out;
    logic [ROWS-1:0] row_out;
    logic          overflow;

    int total = 0;
    int passed = 0;

    window_reader #(
        .ROWS(ROWS), .ADDR_WIDTH(AW), .ADDR_LENGTH(AL), .DATA_WIDTH(DW)
    ) dut (
        .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear),
        .i_valid(in_valid), .o_ready(ready), .i_addr(addr),
        .i_o_x(ox), .i_o_y(oy), .i_row_id(row),
        .o_mem_re(mem_re), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .o_valid(out_valid), .i_ready(out_ready), .o_data(data),
        .o_o_x(x_out), .o_o_y(y_out), .o_row_id(row_out),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem_re ? DW'(mem_addr) + 8'd16 : 8'h00;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic data_t expect_data(input addr_t a);
        data_t d;
        for (int k = 0; k < AL; k++) d[k] = DW'(a[k]) + 8'd16;
        return d;
    endfunction

    task automatic send(input addr_t a, input logic [AW-1:0] x,
                        input logic [AW-1:0] y, input logic [ROWS-1:0] r);
        @(negedge clk);
        in_valid = 1'b1;
        addr = a; ox = x; oy = y; row = r;
    endtask

    // Starts at acceptance cycle T; returns at the negedge of cycle T+11.
    // inj_k >= 0 pulses a second bundle during cycle T+1+inj_k.
    task automatic expect_window(input addr_t a, input logic [AW-1:0] x,
                                 input logic [AW-1:0] y,
                                 input logic [ROWS-1:0] r,
                                 input int inj_k, input addr_t ia);
        int reads = 0;
        for (int k = 0; k < AL; k++) begin
            @(negedge clk);
            if (k == inj_k) begin
                in_valid = 1'b1;
                addr = ia; ox = 6'd9; oy = 6'd9; row = 4'b1111;
            end else begin
                in_valid = 1'b0;
            end
            if (mem_re === 1'b1 && mem_addr === a[k]) reads++;
            if (out_valid !== 1'b0) chk("valid_early", out_valid, 0);
        end
        chk("read_seq", reads, AL);
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain_re", mem_re, 0);
        chk("drain_valid", out_valid, 0);
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", data, expect_data(a));
        chk("hold_x", x_out, x);
        chk("hold_y", y_out, y);
        chk("hold_row", row_out, r);
    endtask

    initial begin
        addr_t a1, a2, a3, a4, aj;
        data_t d1;
        int bad;
        a1 = {6'd0, 6'd1, 6'd2, 6'd6, 6'd7, 6'd8, 6'd12, 6'd13, 6'd14};
        a2 = {6'd5, 6'd10, 6'd15, 6'd20, 6'd25, 6'd30, 6'd35, 6'd40, 6'd45};
        a3 = {6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9};
        a4 = {6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58, 6'd57, 6'd56, 6'd55};
        aj = {6'd33, 6'd33, 6'd33, 6'd33, 6'd33, 6'd33, 6'd33, 6'd33, 6'd33};

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_re", mem_re, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_tags", {x_out, y_out, row_out}, 0);
        chk("rst_ovf", overflow, 0);
        nrst = 1'b1;

        // Single window, then a 5-cycle stall
        send(a1, 6'd2, 6'd3, 4'b0100);
        expect_window(a1, 6'd2, 6'd3, 4'b0100, -1, aj);
        d1 = data;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || data !== d1 || mem_re !== 1'b0 ||
                x_out !== 6'd2 || y_out !== 6'd3 || row_out !== 4'b0100)
                bad++;
        end
        chk("stall_stable", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_ready", ready, 1);
        chk("hs_valid", out_valid, 0);
        out_ready = 1'b0;

`ifndef WINDOW_READER_SKID_EN
        // Second pulse mid-fetch is dropped and flagged
        send(a2, 6'd7, 6'd1, 4'b0001);
        expect_window(a2, 6'd7, 6'd1, 4'b0001, 2, aj);
        chk("ovf_set", overflow, 1);
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_re !== 1'b0) bad++;
        end
        chk("ovf_no_reads", bad, 0);
        chk("ovf_sticky", overflow, 1);
        out_ready = 1'b0;
`else
        // Back-to-back through the skid buffer
        out_ready = 1'b1;
        send(a1, 6'd2, 6'd3, 4'b0100);
        expect_window(a1, 6'd2, 6'd3, 4'b0100, 2, a2);
        expect_window(a2, 6'd9, 6'd9, 4'b1111, -1, aj);
        chk("skid_ovf", overflow, 0);
        @(negedge clk);
        out_ready = 1'b0;
`endif

        // Synchronous clear mid-fetch
        send(a3, 6'd4, 6'd5, 4'b0010);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        reg_clear = 1'b1;
        @(negedge clk);
        reg_clear = 1'b0;
        chk("clr_re", mem_re, 0);
        chk("clr_ready", ready, 1);
        chk("clr_data", data, 0);
        chk("clr_ovf", overflow, 0);
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || mem_re !== 1'b0) bad++;
        end
        chk("clr_quiet", bad, 0);
        send(a4, 6'd63, 6'd0, 4'b1000);
        expect_window(a4, 6'd63, 6'd0, 4'b1000, -1, aj);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset mid-fetch
        send(a1, 6'd2, 6'd3, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #2 nrst = 1'b0;
        #1;
        chk("arst_re", mem_re, 0);
        chk("arst_ready", ready, 1);
        chk("arst_data", data, 0);
        chk("arst_tags", {x_out, y_out, row_out}, 0);
        chk("arst_valid", out_valid, 0);
        @(negedge clk);
        nrst = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_re !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        chk("arst_quiet", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
